// File: rtl/wb_serial_master.sv
// Byte-stream to Wishbone classic bridge: decodes read/write command frames,
// runs one bus cycle per frame and returns a status byte plus any read data.
module wb_serial_master #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BUS_TIMEOUT   = 255,
  parameter int FRAME_TIMEOUT = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  output logic                  o_busy
);

  localparam int BUS_CNT_W = ($clog2(BUS_TIMEOUT + 1) < 8) ? 8 : $clog2(BUS_TIMEOUT + 1);
  localparam int FRM_CNT_W = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [BUS_CNT_W-1:0] BUS_LAST = BUS_CNT_W'(BUS_TIMEOUT - 1);
  localparam logic [FRM_CNT_W-1:0] FRM_LAST = FRM_CNT_W'(FRAME_TIMEOUT - 1);

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] ST_ACK     = 8'hA5;
  localparam logic [7:0] ST_ERR     = 8'hEE;
  localparam logic [7:0] ST_RTY     = 8'hE1;
  localparam logic [7:0] ST_TIMEOUT = 8'hE0;

  typedef enum logic [2:0] {S_CMD, S_ADDR, S_WDATA, S_BUS, S_RESP, S_RDATA} state_t;

  state_t                 state, state_next;
  logic                   we_r;
  logic [31:0]            addr_r;
  logic [DATA_WIDTH-1:0]  wdata_r;
  logic [DATA_WIDTH-1:0]  rdata_r;
  logic [7:0]             status_r;
  logic [7:0]             status_next;
  logic [1:0]             byte_cnt;
  logic [1:0]             tx_idx;
  logic [BUS_CNT_W-1:0]   bus_cnt;
  logic [FRM_CNT_W-1:0]   frame_cnt;
  logic                   rx_fire;
  logic                   tx_fire;
  logic                   bus_done;
  logic                   frame_expired;
  logic                   cmd_valid;

  assign rx_fire       = i_rx_valid & o_rx_ready;
  assign tx_fire       = o_tx_valid & i_tx_ready;
  assign cmd_valid     = (i_rx_data == CMD_WRITE) || (i_rx_data == CMD_READ);
  assign bus_done      = wb_err_i | wb_rty_i | wb_ack_i | (bus_cnt == BUS_LAST);
  assign frame_expired = !rx_fire && (frame_cnt == FRM_LAST);
  assign wb_adr_o      = addr_r[ADDR_WIDTH-1:0];
  assign wb_dat_o      = wdata_r;

  // Termination priority: err, then rty, then ack, and timeout only if none of them.
  always_comb begin
    status_next = ST_TIMEOUT;
    if (wb_err_i)      status_next = ST_ERR;
    else if (wb_rty_i) status_next = ST_RTY;
    else if (wb_ack_i) status_next = ST_ACK;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_CMD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_CMD:   if (rx_fire && cmd_valid) state_next = S_ADDR;
      S_ADDR: begin
        if (rx_fire && byte_cnt == 2'd3) state_next = we_r ? S_WDATA : S_BUS;
        else if (frame_expired)          state_next = S_CMD;
      end
      S_WDATA: begin
        if (rx_fire && byte_cnt == 2'd3) state_next = S_BUS;
        else if (frame_expired)          state_next = S_CMD;
      end
      S_BUS:   if (bus_done) state_next = S_RESP;
      S_RESP:  if (tx_fire) state_next = (!we_r && status_r == ST_ACK) ? S_RDATA : S_CMD;
      S_RDATA: if (tx_fire && tx_idx == 2'd3) state_next = S_CMD;
      default: state_next = S_CMD;
    endcase
  end

  always_comb begin
    o_rx_ready = 1'b0;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    wb_cyc_o   = 1'b0;
    wb_stb_o   = 1'b0;
    wb_we_o    = 1'b0;
    wb_sel_o   = 4'h0;
    o_busy     = (state != S_CMD);
    case (state)
      S_CMD, S_ADDR, S_WDATA: o_rx_ready = 1'b1;
      S_BUS: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = we_r;
        wb_sel_o = 4'hF;
      end
      S_RESP: begin
        o_tx_valid = 1'b1;
        o_tx_data  = status_r;
      end
      S_RDATA: begin
        o_tx_valid = 1'b1;
        o_tx_data  = rdata_r[DATA_WIDTH-1 -: 8];
      end
      default: ;
    endcase
  end

  // Frame assembly, bus-cycle bookkeeping and read-data serialisation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      rdata_r   <= '0;
      status_r  <= 8'h00;
      byte_cnt  <= 2'd0;
      tx_idx    <= 2'd0;
      bus_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      bus_cnt <= '0;
      case (state)
        S_CMD: begin
          byte_cnt  <= 2'd0;
          frame_cnt <= '0;
          if (rx_fire && cmd_valid) we_r <= (i_rx_data == CMD_WRITE);
        end
        S_ADDR, S_WDATA: begin
          if (rx_fire) begin
            byte_cnt  <= byte_cnt + 2'd1;
            frame_cnt <= '0;
            if (state == S_ADDR) addr_r  <= {addr_r[23:0], i_rx_data};
            else                 wdata_r <= {wdata_r[DATA_WIDTH-9:0], i_rx_data};
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        S_BUS: begin
          bus_cnt <= bus_cnt + 1'b1;
          tx_idx  <= 2'd0;
          if (bus_done) begin
            status_r <= status_next;
            if (!we_r && !wb_err_i && !wb_rty_i && wb_ack_i) rdata_r <= wb_dat_i;
          end
        end
        S_RDATA: begin
          if (tx_fire) begin
            rdata_r <= {rdata_r[DATA_WIDTH-9:0], 8'h00};
            tx_idx  <= tx_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_serial_master.sv
// Directed bench for wb_serial_master: a vector table of complete frames plus
// hand sequences for stray commands, frame timeout and mid-cycle reset.
module tb_wb_serial_master;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;
  logic        o_busy;

  // Slave behaviour: 0 zero-wait ack, 1 silent, 2 err, 3 rty, 4 ack on 16th cycle.
  int          slave_mode = 0;
  logic [31:0] slave_rdata = 32'h0;
  bit          rnd_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  // Monitor-owned records, read by the stimulus process only.
  logic [7:0]  rsp_q[$];
  int          bus_cycles = 0;
  int          cyc_run = 0;
  logic        prev_cyc = 1'b0;
  logic [31:0] cap_adr, cap_dat;
  logic        cap_we, cap_stb;
  logic [3:0]  cap_sel;
  int          stab_viol = 0;
  logic        pend = 1'b0;
  logic [7:0]  pend_data = 8'h00;

  wb_serial_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BUS_TIMEOUT(16), .FRAME_TIMEOUT(100)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  assign wb_dat_i = slave_rdata;
  assign wb_ack_i = wb_cyc_o && wb_stb_o &&
                    (slave_mode == 0 || (slave_mode == 4 && cyc_run == 16));
  assign wb_err_i = wb_cyc_o && wb_stb_o && slave_mode == 2;
  assign wb_rty_i = wb_cyc_o && wb_stb_o && slave_mode == 3;

  // Transmit handshake: always ready, or a coin toss per cycle.
  always @(posedge i_clk) begin
    #1;
    i_tx_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Sample bus and response activity mid-cycle, away from the active edge.
  always @(negedge i_clk) begin
    if (wb_cyc_o) begin
      if (!prev_cyc) begin
        cyc_run    = 1;
        bus_cycles = bus_cycles + 1;
        cap_adr    = wb_adr_o;
        cap_dat    = wb_dat_o;
        cap_we     = wb_we_o;
        cap_sel    = wb_sel_o;
        cap_stb    = wb_stb_o;
      end else begin
        cyc_run = cyc_run + 1;
      end
    end
    prev_cyc = wb_cyc_o;
    if (pend && o_tx_valid && o_tx_data != pend_data) stab_viol = stab_viol + 1;
    if (o_tx_valid && i_tx_ready) rsp_q.push_back(o_tx_data);
    pend      = o_tx_valid && !i_tx_ready && !i_rst;
    pend_data = o_tx_data;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          mode;
    logic [31:0] rdata;
    bit          rnd;
    int          exp_cyc;
    int          exp_len;
    logic [39:0] exp_bytes;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge i_clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    while (!o_rx_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge i_clk);
    while (o_busy && n < 400) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput({name, " idle within budget"}, 32'(o_busy), 32'h0);
    repeat (3) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    send_byte(we ? 8'h01 : 8'h02);
    for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
    if (we) for (int i = 3; i >= 0; i--) send_byte(wdata[8*i +: 8]);
  endtask

  task automatic applyStimulus(input string name, input vec_t v);
    int cyc_base, rsp_base, got_len;
    slave_mode  = v.mode;
    slave_rdata = v.rdata;
    rnd_ready   = v.rnd;
    cyc_base    = bus_cycles;
    rsp_base    = rsp_q.size();
    send_frame(v.we, v.addr, v.wdata);
    wait_idle(name);
    checkOutput({name, " bus cycle count"}, 32'(bus_cycles - cyc_base), 32'h1);
    checkOutput({name, " cyc length"}, 32'(cyc_run), 32'(v.exp_cyc));
    checkOutput({name, " adr"}, cap_adr, v.addr);
    checkOutput({name, " we"}, 32'(cap_we), 32'(v.we));
    checkOutput({name, " sel"}, 32'(cap_sel), 32'hF);
    checkOutput({name, " stb"}, 32'(cap_stb), 32'h1);
    if (v.we) checkOutput({name, " dat_o"}, cap_dat, v.wdata);
    got_len = rsp_q.size() - rsp_base;
    checkOutput({name, " response length"}, 32'(got_len), 32'(v.exp_len));
    for (int i = 0; i < v.exp_len && i < got_len; i++)
      checkOutput({name, " response byte"}, 32'(rsp_q[rsp_base + i]),
                  32'(v.exp_bytes[39 - 8*i -: 8]));
    rnd_ready = 1'b0;
  endtask

  initial begin
    int cyc_base, rsp_base;
    //          we    addr          wdata         mode rdata         rnd cyc len bytes
    vecs[0] = '{1'b1, 32'h00000000, 32'h0000002A, 0, 32'h0,        0, 1,  1, 40'hA5_00000000};
    vecs[1] = '{1'b0, 32'h00000004, 32'h0,        0, 32'h1234ABCD, 1, 1,  5, 40'hA5_1234ABCD};
    vecs[2] = '{1'b0, 32'h00000008, 32'h0,        1, 32'h55AA55AA, 0, 16, 1, 40'hE0_00000000};
    vecs[3] = '{1'b1, 32'h0000000C, 32'h11223344, 2, 32'h0,        0, 1,  1, 40'hEE_00000000};
    vecs[4] = '{1'b0, 32'h00000010, 32'h0,        3, 32'hFFFFFFFF, 0, 1,  1, 40'hE1_00000000};
    vecs[5] = '{1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 0, 32'h0,        0, 1,  1, 40'hA5_00000000};
    vecs[6] = '{1'b0, 32'h80000000, 32'h0,        4, 32'h0BADF00D, 1, 16, 5, 40'hA5_0BADF00D};
    vecs[7] = '{1'b0, 32'h00000020, 32'h0,        2, 32'h87654321, 0, 1,  1, 40'hEE_00000000};

    i_rst      = 1'b1;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("reset cyc", 32'(wb_cyc_o), 32'h0);
    checkOutput("reset stb", 32'(wb_stb_o), 32'h0);
    checkOutput("reset we", 32'(wb_we_o), 32'h0);
    checkOutput("reset sel", 32'(wb_sel_o), 32'h0);
    checkOutput("reset adr", wb_adr_o, 32'h0);
    checkOutput("reset dat_o", wb_dat_o, 32'h0);
    checkOutput("reset tx_valid", 32'(o_tx_valid), 32'h0);
    checkOutput("reset tx_data", 32'(o_tx_data), 32'h0);
    checkOutput("reset busy", 32'(o_busy), 32'h0);
    checkOutput("reset rx_ready", 32'(o_rx_ready), 32'h1);

    for (int i = 0; i < 8; i++) applyStimulus($sformatf("vec%0d", i), vecs[i]);
    checkOutput("tx_data stable while stalled", 32'(stab_viol), 32'h0);

    // Stray command byte is swallowed without a response or bus cycle.
    cyc_base = bus_cycles;
    rsp_base = rsp_q.size();
    send_byte(8'h7F);
    repeat (4) @(negedge i_clk);
    checkOutput("stray busy", 32'(o_busy), 32'h0);
    checkOutput("stray bus cycles", 32'(bus_cycles - cyc_base), 32'h0);
    checkOutput("stray response", 32'(rsp_q.size() - rsp_base), 32'h0);
    applyStimulus("after stray", vecs[1]);

    // Partial write frame abandoned by silence longer than the frame timeout.
    cyc_base = bus_cycles;
    rsp_base = rsp_q.size();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge i_clk);
    checkOutput("partial busy mid-frame", 32'(o_busy), 32'h1);
    repeat (150) @(negedge i_clk);
    checkOutput("partial busy after timeout", 32'(o_busy), 32'h0);
    checkOutput("partial bus cycles", 32'(bus_cycles - cyc_base), 32'h0);
    checkOutput("partial response", 32'(rsp_q.size() - rsp_base), 32'h0);
    applyStimulus("after partial", vecs[5]);

    // Reset while the bus cycle is outstanding drops it and any response.
    slave_mode = 1;
    rsp_base   = rsp_q.size();
    send_frame(1'b0, 32'h00000040, 32'h0);
    repeat (5) @(negedge i_clk);
    checkOutput("pre-reset cyc", 32'(wb_cyc_o), 32'h1);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("mid reset cyc", 32'(wb_cyc_o), 32'h0);
    checkOutput("mid reset stb", 32'(wb_stb_o), 32'h0);
    checkOutput("mid reset tx_valid", 32'(o_tx_valid), 32'h0);
    checkOutput("mid reset busy", 32'(o_busy), 32'h0);
    i_rst = 1'b0;
    repeat (30) @(negedge i_clk);
    checkOutput("mid reset no response", 32'(rsp_q.size() - rsp_base), 32'h0);
    applyStimulus("after reset", vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global timeout: got running, expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
